// File: rtl/event_dispatch.sv
// -----------------------------------------------------------------------------
// event_dispatch
//   Sits between an event producer/consumer pair and an external min-heap.
//   New events are pushed into the heap. The heap minimum is popped into a
//   single output register as soon as that register is free. Once an event
//   is in the output register it is committed and is never re-sorted.
//
//   The heap's own ready output is not used, because it depends
//   combinationally on enq. Instead, every heap operation is followed by one
//   dead cycle (ENQ_WAIT / DEQ_WAIT), which gives the heap time to settle.
//   The heap's rst_n should be driven with ~rst, so that both sides are
//   emptied together.
//
//   Optional feature (macro EVENT_DISPATCH_BYPASS_EN):
//     When the heap is empty and the output register is free, an offered
//     event is loaded straight into the output register and the heap is
//     skipped.
//
// Parameters
//   WIDTH  event word width (same as the heap data width)
//   DEPTH  heap depth; the heap holds (2^DEPTH)-1 events
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    producer handshake, with in_data
//   out_valid/out_ready  consumer handshake, with out_data (registered)
//   hp_enq, hp_deq       heap operation strobes (never both in one cycle)
//   hp_inp_data          enqueue data to the heap (equals in_data)
//   hp_out_data          current heap minimum
//   hp_empty, hp_full    heap status flags
//   hp_elem_cnt          number of events in the heap
//   level                total events held (heap + output register)
// -----------------------------------------------------------------------------
module event_dispatch #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             hp_enq,
    output logic             hp_deq,
    output logic [WIDTH-1:0] hp_inp_data,
    input  logic [WIDTH-1:0] hp_out_data,
    input  logic             hp_empty,
    input  logic             hp_full,
    input  logic [DEPTH-1:0] hp_elem_cnt,
    output logic [DEPTH:0]   level
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENQ_WAIT = 2'd1,
        DEQ_WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   do_enq, do_deq, do_byp;
    logic   out_free;

    // The output register can take a new event this cycle if it is empty,
    // or if its current event is being handed to the consumer.
    assign out_free = !out_valid || out_ready;

    always_comb begin
        state_nxt = state;
        do_enq    = 1'b0;
        do_deq    = 1'b0;
        do_byp    = 1'b0;
        if (rst) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // Refilling the output has priority over accepting input.
                    if (out_free && !hp_empty) begin
                        do_deq    = 1'b1;
                        state_nxt = DEQ_WAIT;
                    end
`ifdef EVENT_DISPATCH_BYPASS_EN
                    else if (out_free && hp_empty && in_valid) begin
                        // Nothing is queued, so the new event is the minimum.
                        do_byp = 1'b1;
                    end
`endif
                    else if (in_valid && !hp_full) begin
                        do_enq    = 1'b1;
                        state_nxt = ENQ_WAIT;
                    end
                end
                ENQ_WAIT: state_nxt = IDLE;
                DEQ_WAIT: state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    assign hp_enq      = do_enq;
    assign hp_deq      = do_deq;
    assign in_ready    = do_enq | do_byp;
    assign hp_inp_data = in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            if (do_deq) begin
                out_valid <= 1'b1;
                out_data  <= hp_out_data;
            end else if (do_byp) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign level = {1'b0, hp_elem_cnt} + {{DEPTH{1'b0}}, out_valid};

endmodule

// File: tb/tb_event_dispatch.sv
module tb_event_dispatch;
    localparam int WIDTH = 32;
    localparam int DEPTH = 6;
    localparam int CAP   = (1 << DEPTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_data;
    logic             hp_enq, hp_deq;
    logic [WIDTH-1:0] hp_inp_data, hp_out_data;
    logic             hp_empty, hp_full;
    logic [DEPTH-1:0] hp_elem_cnt;
    logic [DEPTH:0]   level;

    int n_assert = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] sb[$];

    always #5 clk = ~clk;

    event_dispatch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .hp_enq(hp_enq), .hp_deq(hp_deq), .hp_inp_data(hp_inp_data),
        .hp_out_data(hp_out_data), .hp_empty(hp_empty), .hp_full(hp_full),
        .hp_elem_cnt(hp_elem_cnt), .level(level)
    );

    // Behavioural min-heap: unordered store plus a combinational minimum search.
    logic [WIDTH-1:0] hmem [0:CAP-1];
    int               hcnt = 0;
    int               hmin_idx;
    logic [WIDTH-1:0] hmin;

    always_comb begin
        hmin     = '0;
        hmin_idx = 0;
        for (int i = 0; i < CAP; i++) begin
            if (i < hcnt && (i == 0 || hmem[i] < hmin)) begin
                hmin     = hmem[i];
                hmin_idx = i;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            hcnt <= 0;
        end else if (hp_enq && !hp_deq) begin
            hmem[hcnt] <= hp_inp_data;
            hcnt       <= hcnt + 1;
        end else if (hp_deq && !hp_enq) begin
            hmem[hmin_idx] <= hmem[hcnt-1];
            hcnt           <= hcnt - 1;
        end
    end

    assign hp_out_data = hmin;
    assign hp_empty    = (hcnt == 0);
    assign hp_full     = (hcnt == CAP);
    assign hp_elem_cnt = hcnt[DEPTH-1:0];

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle protocol checks and scoreboard pop on each consumer handshake.
    logic prev_op = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_op <= 1'b0;
        end else begin
            chk("enq_deq_exclusive", {31'd0, hp_enq && hp_deq}, 0);
            chk("op_spacing", {31'd0, prev_op && (hp_enq || hp_deq)}, 0);
            chk("hp_inp_data", hp_inp_data, in_data);
`ifndef EVENT_DISPATCH_BYPASS_EN
            chk("ready_without_enq", {31'd0, in_ready && !hp_enq}, 0);
`endif
            prev_op <= hp_enq || hp_deq;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", out_data, 32'hDEAD_BEEF);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = sb.pop_front();
                    chk("out_data_order", out_data, e);
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_accepted", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        chk("drain_complete", sb.size(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("drained_level", {25'd0, level}, 0);
        chk("drained_out_valid", {31'd0, out_valid}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        // ---- reset state (in_valid high to prove in_ready is gated) ----
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_hp_enq", {31'd0, hp_enq}, 0);
        chk("rst_hp_deq", {31'd0, hp_deq}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;

        // ---- held output, later smaller arrivals do not displace it ----
        send(32'h30); send(32'h10); send(32'h20);
        sb.push_back(32'h30); sb.push_back(32'h10); sb.push_back(32'h20);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_out_valid", {31'd0, out_valid}, 1);
            chk("held_out_data", out_data, 32'h30);
        end
        chk("held_level", {25'd0, level}, 3);
        @(posedge clk); #1;
        drain(40);

        // ---- fill heap to capacity behind a held output ----
        for (int i = 0; i < CAP + 1; i++) send(32'd1000 - i);
        sb.push_back(32'd1000);
        for (int v = 1000 - CAP; v < 1000; v++) sb.push_back(v);
        repeat (3) @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_in_ready", {31'd0, in_ready}, 0);
            chk("full_hp_enq", {31'd0, hp_enq}, 0);
        end
        chk("full_level", {25'd0, level}, 64);
        chk("full_out_data", out_data, 32'd1000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain(400);

        // ---- dequeue beats enqueue; enqueue two cycles later ----
        send(32'h50); send(32'h60);
        sb.push_back(32'h50); sb.push_back(32'h60); sb.push_back(32'h70);
        repeat (3) @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h70; out_ready = 1'b1;
        @(negedge clk);
        chk("prio_hp_deq", {31'd0, hp_deq}, 1);
        chk("prio_hp_enq", {31'd0, hp_enq}, 0);
        chk("prio_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("prio_wait_enq", {31'd0, hp_enq}, 0);
        @(negedge clk);
        chk("prio_late_enq", {31'd0, hp_enq}, 1);
        chk("prio_late_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain(40);

        // ---- reset with events in flight ----
        for (int i = 0; i < 5; i++) send(32'h11 + i);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h77;
        @(negedge clk);
        chk("midrst_hp_enq", {31'd0, hp_enq}, 0);
        chk("midrst_hp_deq", {31'd0, hp_deq}, 0);
        chk("midrst_in_ready", {31'd0, in_ready}, 0);
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        chk("midrst_level", {25'd0, level}, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_quiet", {30'd0, hp_enq, hp_deq}, 0);
            chk("postrst_out_valid", {31'd0, out_valid}, 0);
        end
        @(posedge clk); #1;

        // ---- single event into an empty block ----
        in_valid = 1'b1; in_data = 32'h42;
        sb.push_back(32'h42);
        @(negedge clk);
`ifdef EVENT_DISPATCH_BYPASS_EN
        chk("byp_t_hp_enq", {31'd0, hp_enq}, 0);
        chk("byp_t_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("byp_t1_out_valid", {31'd0, out_valid}, 1);
        chk("byp_t1_out_data", out_data, 32'h42);
        chk("byp_t1_hp_enq", {31'd0, hp_enq}, 0);
`else
        chk("lat_t_hp_enq", {31'd0, hp_enq}, 1);
        chk("lat_t_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_t1_hp_deq", {31'd0, hp_deq}, 0);
        chk("lat_t1_out_valid", {31'd0, out_valid}, 0);
        @(negedge clk);
        chk("lat_t2_hp_deq", {31'd0, hp_deq}, 1);
        @(negedge clk);
        chk("lat_t3_out_valid", {31'd0, out_valid}, 1);
        chk("lat_t3_out_data", out_data, 32'h42);
`endif
        @(posedge clk); #1;
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute guard so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/event_dispatch.md
EVENT_DISPATCH -- requirements
Module: event_dispatch

Interface
REQ-001 SHALL have parameter WIDTH, default 32: event word width, identical to the heap data width.
REQ-002 SHALL have parameter DEPTH, default 6: heap depth; the heap holds (2^DEPTH)-1 events.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: a new event is offered.
REQ-006 SHALL have port in_ready, output, 1: the offered event is accepted this cycle.
REQ-007 SHALL have port in_data, input, WIDTH: the new event word.
REQ-008 SHALL have port out_valid, output, 1: the output register holds an event.
REQ-009 SHALL have port out_ready, input, 1: the consumer takes the event when out_valid is also high.
REQ-010 SHALL have port out_data, output, WIDTH: the event in the output register.
REQ-011 SHALL have port hp_enq, output, 1: enqueue strobe to the heap.
REQ-012 SHALL have port hp_deq, output, 1: dequeue strobe to the heap.
REQ-013 SHALL have port hp_inp_data, output, WIDTH: enqueue data to the heap; equals in_data.
REQ-014 SHALL have port hp_out_data, input, WIDTH: current heap minimum.
REQ-015 SHALL have ports hp_empty and hp_full, input, 1 each: heap status flags.
REQ-016 SHALL have port hp_elem_cnt, input, DEPTH: heap element count.
REQ-017 SHALL have port level, output, DEPTH+1: hp_elem_cnt + out_valid.

Function
REQ-018 SHALL implement an FSM with states IDLE, ENQ_WAIT and DEQ_WAIT; no heap operation is issued in either WAIT state.
REQ-019 ENQ_WAIT and DEQ_WAIT SHALL each last exactly one cycle, then return to IDLE.
REQ-020 In IDLE, if out_valid is 0 (or is cleared by an out handshake this cycle) and hp_empty is 0, the block SHALL assert hp_deq, load hp_out_data into out_data, set out_valid, and go to DEQ_WAIT.
REQ-021 Otherwise in IDLE, if in_valid is 1 and hp_full is 0, the block SHALL assert hp_enq and in_ready and go to ENQ_WAIT.
REQ-022 Dequeue SHALL have priority over enqueue when both are possible.
REQ-023 hp_enq and hp_deq SHALL never be asserted in the same cycle, because the heap treats both together as a no-op.
REQ-024 in_ready SHALL be asserted only in a cycle that asserts hp_enq (or loads the bypass, REQ-032); it is combinational from state, in_valid, hp_full and the out handshake.
REQ-025 The heap ready output SHALL NOT be used: it depends combinationally on enq. Spacing is enforced by this block's FSM.
REQ-026 out_valid SHALL clear on out_valid & out_ready unless it is reloaded in the same cycle.
REQ-027 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 An event in the output register is committed: it SHALL NOT be re-sorted against later, smaller arrivals.
REQ-029 Latency from hp_deq to out_valid SHALL be 1 cycle; peak throughput SHALL be one event every 2 cycles on each side.

Reset
REQ-030 While rst=1, the block SHALL force state=IDLE, out_valid=0, out_data=0, hp_enq=0, hp_deq=0 and in_ready=0.
REQ-031 Reset mid-operation SHALL discard the held event; the heap's rst_n is driven with ~rst so both sides empty together.

Configuration
REQ-032 With macro EVENT_DISPATCH_BYPASS_EN defined, in IDLE with hp_empty=1, out_valid=0 (or draining) and in_valid=1, the block SHALL load in_data directly into out_data, set out_valid the next cycle, assert in_ready, issue no heap operation, and stay in IDLE.
REQ-033 Without EVENT_DISPATCH_BYPASS_EN, every event SHALL pass through the heap.

Verification
REQ-034 Scenario: reset, then enqueue 0x30, 0x10, 0x20 with out_ready=0. Required: hp_enq is never asserted on back-to-back cycles, and out_data=0x30 is held. Then set out_ready=1: the consumer receives 0x10, then 0x20.
REQ-035 Scenario: fill the heap with 63 events while out_valid=1 and out_ready=0. Required: hp_full=1 and in_ready stays 0 while in_valid=1; level=64.
REQ-036 Scenario: in_valid=1 and hp_empty=0 while out is empty. Required: hp_deq wins, hp_enq=0 that cycle, and enqueue occurs 2 cycles later.
REQ-037 Scenario: assert rst with 5 events in flight. Required: out_valid=0 and level=0 the next cycle, and no spurious hp_enq or hp_deq.
REQ-038 Scenario: heap empty, in_data=0x42. With bypass, out_valid=1 the next cycle and hp_enq stays 0. Without bypass, hp_enq fires at t, hp_deq at t+2, and out_valid=1 at t+3.
